// File: rtl/vessel_motion_if.sv
// vessel_motion_if: orbit-state-machine <-> vessel-motion signal bundle.
// The keycode field only exists when VESSEL_THRUST_EN is defined.
interface vessel_motion_if;
  logic               welcomepage;
  logic        [1:0]  state;
  logic        [31:0] theta;
  logic signed [10:0] PlanX;
  logic signed [10:0] PlanY;
  logic        [10:0] PlanS;
  logic signed [10:0] VesselX;
  logic signed [10:0] VesselY;
  logic        [10:0] VesselS;
  logic signed [5:0]  VelX;
  logic signed [5:0]  VelY;
  logic               lost;
`ifdef VESSEL_THRUST_EN
  logic        [15:0] keycode;

  modport master (
    output welcomepage, state, theta, PlanX, PlanY, PlanS, keycode,
    input  VesselX, VesselY, VesselS, VelX, VelY, lost
  );
  modport slave (
    input  welcomepage, state, theta, PlanX, PlanY, PlanS, keycode,
    output VesselX, VesselY, VesselS, VelX, VelY, lost
  );
`else
  modport master (
    output welcomepage, state, theta, PlanX, PlanY, PlanS,
    input  VesselX, VesselY, VesselS, VelX, VelY, lost
  );
  modport slave (
    input  welcomepage, state, theta, PlanX, PlanY, PlanS,
    output VesselX, VesselY, VesselS, VelX, VelY, lost
  );
`endif
endinterface

// File: rtl/vessel_motion.sv
// vessel_motion: per-frame vessel position/velocity update.
//   bound    -> vessel placed on a circle around the current planet
//   leaving  -> tangential launch velocity latched from the orbit angle
//   unbound  -> position integrates velocity, wrapping at the screen edges
//   arriving -> position held, velocity zeroed
// Optional keyboard thrust while unbound: define VESSEL_THRUST_EN.
module vessel_motion #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int START_X      = 100,
  parameter int START_Y      = 240,
  parameter int VESSEL_SIZE  = 4,
  parameter int ORBIT_GAP    = 8,
  parameter int LAUNCH_SPEED = 4,
  parameter int LOST_FRAMES  = 600
) (
  input  logic           frame_clk,
  input  logic           Reset,
  vessel_motion_if.slave bus
);

  localparam int CW = $clog2(LOST_FRAMES + 1);
  localparam logic [CW-1:0]      LOST_MAX = CW'(LOST_FRAMES);
  localparam logic signed [11:0] LIM_W    = 12'(SCREEN_W);
  localparam logic signed [11:0] LIM_H    = 12'(SCREEN_H);
  localparam logic signed [10:0] X0       = 11'(START_X);
  localparam logic signed [10:0] Y0       = 11'(START_Y);

  // First quadrant of sin in Q0.7, k = 0..16.
  function automatic logic [6:0] quarter_sine(input logic [4:0] k);
    case (k)
      5'd0:    quarter_sine = 7'd0;
      5'd1:    quarter_sine = 7'd12;
      5'd2:    quarter_sine = 7'd25;
      5'd3:    quarter_sine = 7'd37;
      5'd4:    quarter_sine = 7'd49;
      5'd5:    quarter_sine = 7'd60;
      5'd6:    quarter_sine = 7'd71;
      5'd7:    quarter_sine = 7'd81;
      5'd8:    quarter_sine = 7'd90;
      5'd9:    quarter_sine = 7'd98;
      5'd10:   quarter_sine = 7'd106;
      5'd11:   quarter_sine = 7'd112;
      5'd12:   quarter_sine = 7'd117;
      5'd13:   quarter_sine = 7'd122;
      5'd14:   quarter_sine = 7'd125;
      5'd15:   quarter_sine = 7'd126;
      5'd16:   quarter_sine = 7'd127;
      default: quarter_sine = 7'd0;
    endcase
  endfunction

  // Full-circle sine from the quarter table: odd quadrants mirror, lower half negates.
  function automatic logic signed [7:0] sine_q7(input logic [5:0] idx);
    logic [4:0] k;
    logic [6:0] mag;
    k   = idx[4] ? (5'd16 - {1'b0, idx[3:0]}) : {1'b0, idx[3:0]};
    mag = quarter_sine(k);
    sine_q7 = idx[5] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  // Add a small velocity to a coordinate and fold it back into [0, lim).
  function automatic logic signed [10:0] wrap_add(input logic signed [10:0] p,
                                                   input logic signed [5:0]  v,
                                                   input logic signed [11:0] lim);
    logic signed [11:0] s;
    s = {p[10], p} + {{6{v[5]}}, v};
    if (s < 12'sd0) begin
      s = s + lim;
    end else if (s >= lim) begin
      s = s - lim;
    end else begin
      s = s;
    end
    wrap_add = s[10:0];
  endfunction

`ifdef VESSEL_THRUST_EN
  // One unit of thrust, clamped to +/-15.
  function automatic logic signed [5:0] sat_step(input logic signed [5:0] v,
                                                 input logic signed [1:0] d);
    logic signed [6:0] s;
    s = {v[5], v} + {{5{d[1]}}, d};
    if (s > 7'sd15) begin
      sat_step = 6'sd15;
    end else if (s < -7'sd15) begin
      sat_step = -6'sd15;
    end else begin
      sat_step = s[5:0];
    end
  endfunction
`endif

  logic signed [10:0] r_x, r_y;
  logic signed [5:0]  r_vx, r_vy;
  logic [CW-1:0]      r_cnt;
  logic               r_lost;

  logic signed [10:0] w_x_nxt, w_y_nxt;
  logic signed [5:0]  w_vx_nxt, w_vy_nxt;
  logic [CW-1:0]      w_cnt_nxt;

  logic [5:0]         w_idx;
  logic signed [7:0]  w_sin, w_cos;
  logic [11:0]        w_rad;
  logic signed [20:0] w_rcos, w_rsin, w_orb_x, w_orb_y;
  logic signed [11:0] w_lsin, w_lcos, w_lvx, w_lvy;
  logic signed [5:0]  w_tvx, w_tvy;
  logic               w_unused;

  assign w_idx  = bus.theta[5:0];
  assign w_sin  = sine_q7(w_idx);
  assign w_cos  = sine_q7(w_idx + 6'd16);
  assign w_rad  = {1'b0, bus.PlanS} + 12'(VESSEL_SIZE) + 12'(ORBIT_GAP);

  // Orbit offsets: radius is unsigned so it is zero-extended before the signed multiply.
  assign w_rcos  = $signed({9'd0, w_rad}) * $signed({{13{w_cos[7]}}, w_cos});
  assign w_rsin  = $signed({9'd0, w_rad}) * $signed({{13{w_sin[7]}}, w_sin});
  assign w_orb_x = $signed({{10{bus.PlanX[10]}}, bus.PlanX}) + (w_rcos >>> 7);
  assign w_orb_y = $signed({{10{bus.PlanY[10]}}, bus.PlanY}) - (w_rsin >>> 7);

  // Launch velocity is tangential: (-sin, -cos) scaled by the launch speed.
  assign w_lsin = $signed(12'(LAUNCH_SPEED)) * $signed({{4{w_sin[7]}}, w_sin});
  assign w_lcos = $signed(12'(LAUNCH_SPEED)) * $signed({{4{w_cos[7]}}, w_cos});
  assign w_lvx  = -(w_lsin >>> 7);
  assign w_lvy  = -(w_lcos >>> 7);

`ifdef VESSEL_THRUST_EN
  logic signed [1:0] w_dx, w_dy;

  // Decode WASD into per-axis thrust steps.
  always_comb begin
    w_dx = 2'sd0;
    w_dy = 2'sd0;
    case (bus.keycode)
      16'h001A: w_dy = 2'sb11;
      16'h0016: w_dy = 2'sd1;
      16'h0004: w_dx = 2'sb11;
      16'h0007: w_dx = 2'sd1;
      default: begin
        w_dx = 2'sd0;
        w_dy = 2'sd0;
      end
    endcase
  end

  assign w_tvx = sat_step(r_vx, w_dx);
  assign w_tvy = sat_step(r_vy, w_dy);
`else
  assign w_tvx = r_vx;
  assign w_tvy = r_vy;
`endif

  // Next position/velocity/lost-count from the sampled orbit state.
  always_comb begin
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    w_vx_nxt  = r_vx;
    w_vy_nxt  = r_vy;
    w_cnt_nxt = '0;
    if (bus.welcomepage) begin
      w_x_nxt  = X0;
      w_y_nxt  = Y0;
      w_vx_nxt = 6'sd0;
      w_vy_nxt = 6'sd0;
    end else begin
      case (bus.state)
        2'b00: begin
          w_x_nxt = w_orb_x[10:0];
          w_y_nxt = w_orb_y[10:0];
        end
        2'b01: begin
          w_vx_nxt = w_lvx[5:0];
          w_vy_nxt = w_lvy[5:0];
        end
        2'b10: begin
          w_vx_nxt  = w_tvx;
          w_vy_nxt  = w_tvy;
          w_x_nxt   = wrap_add(r_x, w_tvx, LIM_W);
          w_y_nxt   = wrap_add(r_y, w_tvy, LIM_H);
          w_cnt_nxt = (r_cnt == LOST_MAX) ? r_cnt : r_cnt + CW'(1);
        end
        2'b11: begin
          w_vx_nxt = 6'sd0;
          w_vy_nxt = 6'sd0;
        end
        default: begin
          w_x_nxt = r_x;
          w_y_nxt = r_y;
        end
      endcase
    end
  end

  // Frame register: synchronous reset to the start position, else take the next values.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_x    <= X0;
      r_y    <= Y0;
      r_vx   <= 6'sd0;
      r_vy   <= 6'sd0;
      r_cnt  <= '0;
      r_lost <= 1'b0;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_vx   <= w_vx_nxt;
      r_vy   <= w_vy_nxt;
      r_cnt  <= w_cnt_nxt;
      r_lost <= (w_cnt_nxt == LOST_MAX);
    end
  end

  assign bus.VesselX = r_x;
  assign bus.VesselY = r_y;
  assign bus.VesselS = 11'(VESSEL_SIZE);
  assign bus.VelX    = r_vx;
  assign bus.VelY    = r_vy;
  assign bus.lost    = r_lost;

  // Upper theta bits and the discarded high bits of the wide intermediates.
  assign w_unused = ^{bus.theta[31:6], w_orb_x[20:11], w_orb_y[20:11],
                      w_lvx[11:6], w_lvy[11:6]};

endmodule
